// File: rtl/sat_add_rr_scheduler.sv
// Round-robin shared signed saturating adder with a one-entry tagged output register.
// Optional saturation counter port enabled by SAT_ADD_RR_SCHEDULER_STATS_EN.
module sat_add_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_sum,
    output logic [IDW-1:0]     out_id,
`ifdef SAT_ADD_RR_SCHEDULER_STATS_EN
    output logic [15:0]        sat_count,
`endif
    output logic               out_sat
);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [IDW-1:0]   ptr;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   gid;
    logic             found;
    logic             can_accept;
    logic             xfer;
    int               idx;

    logic [W-1:0]     a_sel;
    logic [W-1:0]     b_sel;
    logic [W:0]       s;
    logic             ovf;
    logic [W-1:0]     sum_d;

    assign can_accept = (state == EMPTY) | (out_ready & out_valid);

    // Rotating priority: scan from the pointer upward, wrapping at N_REQ.
    always_comb begin
        grant = '0;
        gid   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gid        = IDW'(idx);
            end
        end
    end

    assign req_ready = can_accept ? grant : '0;
    assign xfer      = found & can_accept;

    assign a_sel = req_a[int'(gid)*W +: W];
    assign b_sel = req_b[int'(gid)*W +: W];
    assign s     = {a_sel[W-1], a_sel} + {b_sel[W-1], b_sel};
    assign ovf   = s[W] ^ s[W-1];

    always_comb begin
        sum_d = s[W-1:0];
        if (ovf) begin
            sum_d = s[W] ? {1'b1, {(W-1){1'b0}}}
                         : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_comb begin
        state_d = state;
        if (xfer) begin
            state_d = FULL;
        end else if (out_valid && out_ready) begin
            state_d = EMPTY;
        end
    end

    assign out_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum <= '0;
            out_id  <= '0;
            out_sat <= 1'b0;
            ptr     <= '0;
        end else if (xfer) begin
            out_sum <= sum_d;
            out_id  <= gid;
            out_sat <= ovf;
            if (int'(gid) == N_REQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= gid + 1'b1;
            end
        end
    end

`ifdef SAT_ADD_RR_SCHEDULER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (xfer && ovf && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sat_add_rr_scheduler.sv
// Bench for sat_add_rr_scheduler: vector table, directed sequences
// and a negedge reference model feeding a result scoreboard.
module tb_sat_add_rr_scheduler;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_sum;
    logic [IDW-1:0] out_id;
    logic           out_sat;
`ifdef SAT_ADD_RR_SCHEDULER_STATS_EN
    logic [15:0]    sat_count;
`endif

    sat_add_rr_scheduler #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_id    (out_id),
`ifdef SAT_ADD_RR_SCHEDULER_STATS_EN
        .sat_count (sat_count),
`endif
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [W-1:0]   sum;
        logic [IDW-1:0] id;
        logic           sat;
    } res_t;

    res_t           q[$];
    logic           m_full;
    logic [IDW-1:0] m_ptr;

    function automatic res_t model_add(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input int id);
        res_t r;
        int   s;
        int   hi;
        int   lo;
        hi = (1 << (W - 1)) - 1;
        lo = -(1 << (W - 1));
        s = int'($signed(a)) + int'($signed(b));
        r.sat = 1'b0;
        if (s > hi) begin
            s = hi;
            r.sat = 1'b1;
        end else if (s < lo) begin
            s = lo;
            r.sat = 1'b1;
        end
        r.sum = W'(s);
        r.id  = IDW'(id);
        return r;
    endfunction

    // Reference model: predicts grants and results for the coming edge.
    always @(negedge clk) begin : model
        logic [N-1:0] er;
        int           gi;
        int           j;
        res_t         e;
        if (!rst_n) begin
            m_full = 1'b0;
            m_ptr  = '0;
            q.delete();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
        end else begin
            chk("out_valid", 32'(out_valid), 32'(m_full));
            if (m_full && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("sb_sum", 32'(out_sum), 32'(e.sum));
                    chk("sb_id", 32'(out_id), 32'(e.id));
                    chk("sb_sat", 32'(out_sat), 32'(e.sat));
                end
            end
            gi = -1;
            for (int k = 0; k < N; k++) begin
                j = (int'(m_ptr) + k) % N;
                if (gi < 0 && req_valid[j]) gi = j;
            end
            er = '0;
            if (gi >= 0 && (!m_full || out_ready)) er[gi] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(er));
            if (er != '0) begin
                q.push_back(model_add(req_a[gi*W +: W], req_b[gi*W +: W], gi));
                m_ptr  = IDW'((gi + 1) % N);
                m_full = 1'b1;
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         sat;
    } vec_t;

    vec_t tv[9];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tv[0] = '{4'd3,  4'd5,  4'd7,  1'b1};
        tv[1] = '{4'hC,  4'h9,  4'h8,  1'b1};
        tv[2] = '{4'd1,  4'hE,  4'hF,  1'b0};
        tv[3] = '{4'd7,  4'd7,  4'd7,  1'b1};
        tv[4] = '{4'h8,  4'h8,  4'h8,  1'b1};
        tv[5] = '{4'h8,  4'd7,  4'hF,  1'b0};
        tv[6] = '{4'd4,  4'd3,  4'd7,  1'b0};
        tv[7] = '{4'hB,  4'hD,  4'h8,  1'b0};
        tv[8] = '{4'd0,  4'd0,  4'd0,  1'b0};

        req_valid = '0;
        req_a = '0;
        req_b = '0;
        out_ready = 1'b1;
        cyc();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_id", 32'(out_id), 32'd0);
        chk("rst_sat", 32'(out_sat), 32'd0);
        cyc();
        rst_n = 1'b1;

        // Single requester, vector table.
        req_valid = 4'b0001;
        for (int i = 0; i < 9; i++) begin
            req_a[W-1:0] = tv[i].a;
            req_b[W-1:0] = tv[i].b;
            cyc();
            chk("vec_sum", 32'(out_sum), 32'(tv[i].sum));
            chk("vec_sat", 32'(out_sat), 32'(tv[i].sat));
            chk("vec_id", 32'(out_id), 32'd0);
        end
        req_valid = '0;
        cyc();

        // All requesters valid: strict rotation.
        do_reset();
        req_a = {4'd4, 4'd3, 4'd2, 4'd1};
        req_b = {4{4'd2}};
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("rr_id", 32'(out_id), 32'(i % N));
            chk("rr_valid", 32'(out_valid), 32'd1);
        end

        // Backpressure while FULL.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_id", 32'(out_id), 32'd3);
            chk("stall_sum", 32'(out_sum), 32'd6);
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        cyc();
        chk("drain_load_valid", 32'(out_valid), 32'd1);
        chk("drain_load_id", 32'(out_id), 32'd0);
        chk("drain_load_sum", 32'(out_sum), 32'd3);

        // Wrap from pointer=1 with only req2 and req0.
        do_reset();
        req_valid = 4'b0001;
        cyc();
        chk("wrap_first", 32'(out_id), 32'd0);
        req_valid = 4'b0101;
        cyc();
        chk("wrap_req2", 32'(out_id), 32'd2);
        req_valid = 4'b0001;
        cyc();
        chk("wrap_req0", 32'(out_id), 32'd0);
        req_valid = 4'b0011;
        cyc();
        chk("wrap_ptr1", 32'(out_id), 32'd1);
        req_valid = '0;
        cyc();

        // Asynchronous reset mid-stream.
        req_valid = 4'b1111;
        repeat (3) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_sum", 32'(out_sum), 32'd0);
        chk("async_id", 32'(out_id), 32'd0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 4'b1010;
        cyc();
        chk("post_rst_id", 32'(out_id), 32'd1);
        req_valid = '0;
        cyc();

`ifdef SAT_ADD_RR_SCHEDULER_STATS_EN
        do_reset();
        chk("stats_rst", 32'(sat_count), 32'd0);
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            req_a[W-1:0] = (i % 2 == 0) ? 4'd7 : 4'd1;
            req_b[W-1:0] = (i % 2 == 0) ? 4'd6 : 4'd2;
            cyc();
        end
        req_valid = '0;
        cyc();
        chk("stats_count", 32'(sat_count), 32'd3);
        force dut.sat_count = 16'hFFFF;
        #1;
        release dut.sat_count;
        req_valid = 4'b0001;
        req_a[W-1:0] = 4'h8;
        req_b[W-1:0] = 4'hF;
        cyc();
        req_valid = '0;
        cyc();
        chk("stats_stick", 32'(sat_count), 32'hFFFF);
`endif

        repeat (3) cyc();
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
